// File: rtl/vga_pkg.sv
// Shared VGA window constants, register field codes and the rectangle record
// used by the timing generator and the pixel renderer.
package vga_pkg;

  localparam int H_ACTIVE_START = 144;
  localparam int V_ACTIVE_START = 35;
  localparam int H_ACTIVE       = 640;
  localparam int V_ACTIVE       = 480;

  localparam logic [2:0] FLD_X0    = 3'd0;
  localparam logic [2:0] FLD_X1    = 3'd1;
  localparam logic [2:0] FLD_Y0    = 3'd2;
  localparam logic [2:0] FLD_Y1    = 3'd3;
  localparam logic [2:0] FLD_COLOR = 3'd4;
  localparam logic [2:0] FLD_EN    = 3'd5;
  localparam logic [2:0] FLD_RSVD  = 3'd6;
  localparam logic [2:0] FLD_BG    = 3'd7;

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] x1;
    logic [9:0] y0;
    logic [9:0] y1;
    logic [5:0] color;
    logic       en;
  } rect_t;

  // Inclusive range test; lo > hi yields an empty range.
  function automatic logic in_range(input logic [9:0] v,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_rect_renderer_rect_hit.sv
// Single rectangle slot: inclusive bound compare of the translated pixel
// position against one live rectangle record.
module rect_hit
  import vga_pkg::*;
(
  input  rect_t      i_rect,
  input  logic [9:0] i_px,
  input  logic [9:0] i_py,
  output logic       o_hit
);

  logic w_in_x;
  logic w_in_y;

  assign w_in_x = in_range(i_px, i_rect.x0, i_rect.x1);
  assign w_in_y = in_range(i_py, i_rect.y0, i_rect.y1);
  assign o_hit  = i_rect.en && w_in_x && w_in_y;

endmodule

// File: rtl/vga_rect_renderer.sv
// Two-stage pixel renderer: prioritised solid rectangles over a background,
// with shadow registers committed once per frame at x==0,y==0.
module vga_rect_renderer
  import vga_pkg::*;
#(
  parameter int NUM_RECTS = 4,
  parameter int COLOR_W   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [9:0]                    x,
  input  logic [9:0]                    y,
  input  logic                          active,
  input  logic                          hs_in,
  input  logic                          vs_in,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_RECTS)+2:0]  wr_addr,
  input  logic [9:0]                    wr_data,
  output logic [COLOR_W-1:0]            r,
  output logic [COLOR_W-1:0]            g,
  output logic [COLOR_W-1:0]            b,
  output logic                          hs_out,
  output logic                          vs_out,
  output logic                          active_out,
  output logic                          frame_tick
);

  localparam int AW = $clog2(NUM_RECTS) + 3;
  localparam int CW = 3 * COLOR_W;

  logic             w_commit;
  logic [2:0]       w_field;
  logic [AW-1:0]    w_idx;
  logic [9:0]       w_px;
  logic [9:0]       w_py;
  logic [NUM_RECTS-1:0] w_hit;
  logic [CW-1:0]    w_rgb;

  rect_t            r_shadow [NUM_RECTS];
  rect_t            r_live   [NUM_RECTS];
  logic [CW-1:0]    r_bg_shadow;
  logic [CW-1:0]    r_bg_live;
  logic             r_tick;

  logic [NUM_RECTS-1:0] r_hit;
  logic             r_act1;
  logic             r_hs1;
  logic             r_vs1;

  logic [CW-1:0]    r_rgb;
  logic             r_hs2;
  logic             r_vs2;
  logic             r_act2;

  assign w_commit = (x == 10'd0) && (y == 10'd0);
  assign w_field  = wr_addr[2:0];
  assign w_idx    = wr_addr >> 3;
  assign w_px     = x - 10'(H_ACTIVE_START);
  assign w_py     = y - 10'(V_ACTIVE_START);

  // Host writes land in the shadow copies only; the background ignores rect_idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        r_shadow[i] <= '0;
      end
      r_bg_shadow <= '0;
    end else if (wr_en) begin
      if (w_field == FLD_BG) begin
        r_bg_shadow <= wr_data[CW-1:0];
      end
      for (int i = 0; i < NUM_RECTS; i++) begin
        if (w_idx == AW'(i)) begin
          case (w_field)
            FLD_X0:    r_shadow[i].x0    <= wr_data;
            FLD_X1:    r_shadow[i].x1    <= wr_data;
            FLD_Y0:    r_shadow[i].y0    <= wr_data;
            FLD_Y1:    r_shadow[i].y1    <= wr_data;
            FLD_COLOR: r_shadow[i].color <= 6'(wr_data[CW-1:0]);
            FLD_EN:    r_shadow[i].en    <= wr_data[0];
            default:   ;
          endcase
        end
      end
    end
  end

  // Frame commit: live copies take the pre-write shadow values on x==0,y==0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        r_live[i] <= '0;
      end
      r_bg_live <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= w_commit;
      if (w_commit) begin
        r_live    <= r_shadow;
        r_bg_live <= r_bg_shadow;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RECTS; gi++) begin : g_slot
    rect_hit u_rect_hit (
      .i_rect (r_live[gi]),
      .i_px   (w_px),
      .i_py   (w_py),
      .o_hit  (w_hit[gi])
    );
  end

  // Stage 1: per-slot hit vector plus the timing flags it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit  <= '0;
      r_act1 <= 1'b0;
      r_hs1  <= 1'b0;
      r_vs1  <= 1'b0;
    end else begin
      r_hit  <= w_hit;
      r_act1 <= active;
      r_hs1  <= hs_in;
      r_vs1  <= vs_in;
    end
  end

  // Descending scan so the lowest-index hit is the last one to overwrite.
  always_comb begin
    w_rgb = r_bg_live;
    for (int i = NUM_RECTS - 1; i >= 0; i--) begin
      w_rgb = r_hit[i] ? r_live[i].color[CW-1:0] : w_rgb;
    end
    w_rgb = r_act1 ? w_rgb : '0;
  end

  // Stage 2: registered colour and the re-registered timing flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb  <= '0;
      r_hs2  <= 1'b0;
      r_vs2  <= 1'b0;
      r_act2 <= 1'b0;
    end else begin
      r_rgb  <= w_rgb;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_act2 <= r_act1;
    end
  end

  assign r          = r_rgb[CW-1 -: COLOR_W];
  assign g          = r_rgb[2*COLOR_W-1 -: COLOR_W];
  assign b          = r_rgb[COLOR_W-1:0];
  assign hs_out     = r_hs2;
  assign vs_out     = r_vs2;
  assign active_out = r_act2;
  assign frame_tick = r_tick;

endmodule
